grf_nrd_sb: RTL and testbench

Parametrised general-purpose register file for the Ghyston core: one byte-enabled synchronous write port, NRD asynchronous read ports with write-through bypass, and an integrated per-register pending-write scoreboard. It sits between decode/issue, which claims destination registers and reads operands, and writeback, which writes results and releases claims. Optional hardwired-zero R0.

---
 rtl/grf_nrd_sb.sv | 110 +++++++++++
 tb/tb_grf_nrd_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_nrd_sb.sv
// General-purpose register file: one byte-enabled write port, NRD combinational
// read ports with write-through bypass, and a per-register pending-write scoreboard.
module grf_nrd_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_b,
  input  logic                     i_clk_en,
  input  logic                     i_cs_b,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W/8-1:0]      i_wen,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_release,
  input  logic                     i_claim,
  input  logic [ADDR_W-1:0]        i_claim_addr,
  input  logic [NRD*ADDR_W-1:0]    i_raddr,
  output logic [NRD*DATA_W-1:0]    o_dout,
  output logic [NRD-1:0]           o_rd_pend,
  output logic [ADDR_W:0]          o_pend_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              waddr_zero, claim_zero;
  logic              wr_sel, wr_fire, rel_fire, claim_fire;
  logic              cnt_inc, cnt_dec;
  logic [DATA_W-1:0] merge_w;

  assign waddr_zero = (ZERO_R0 != 0) && (i_waddr == '0);
  assign claim_zero = (ZERO_R0 != 0) && (i_claim_addr == '0);

  // Bypass qualifies on select and byte enables only; clk_en gates storage, not visibility.
  assign wr_sel     = !i_cs_b && (|i_wen);
  assign wr_fire    = i_clk_en && wr_sel && !waddr_zero;
  assign rel_fire   = i_clk_en && !i_cs_b && i_release;
  assign claim_fire = i_clk_en && i_claim && !claim_zero;

  always_comb begin
    merge_w = rf_q[i_waddr];
    for (int k = 0; k < NB; k++) begin
      if (i_wen[k]) merge_w[8*k +: 8] = i_din[8*k +: 8];
    end
  end

  // Claim wins a same-address collision, so the release only counts when it
  // clears a set bit that the claim is not re-asserting.
  assign cnt_inc = claim_fire && !pend_q[i_claim_addr];
  assign cnt_dec = rel_fire && pend_q[i_waddr] &&
                   !(claim_fire && (i_claim_addr == i_waddr));

  always_comb begin
    for (int r = 0; r < DEPTH; r++) rf_d[r] = rf_q[r];
    if (wr_fire) rf_d[i_waddr] = merge_w;

    pend_d = pend_q;
    if (rel_fire)   pend_d[i_waddr]      = 1'b0;
    if (claim_fire) pend_d[i_claim_addr] = 1'b1;

    cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      for (int r = 0; r < DEPTH; r++) rf_q[r] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) rf_q[r] <= rf_d[r];
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_pend_cnt = cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;
    logic [DATA_W-1:0] rdata;
    logic              rel_hit, claim_hit;

    assign ra        = i_raddr[p*ADDR_W +: ADDR_W];
    assign ra_zero   = (ZERO_R0 != 0) && (ra == '0);
    assign rel_hit   = rel_fire && (i_waddr == ra);
    assign claim_hit = claim_fire && (i_claim_addr == ra);

    always_comb begin
      rdata = rf_q[ra];
      if (ra_zero) begin
        rdata = '0;
      end else if (wr_sel && (i_waddr == ra)) begin
        rdata = merge_w;
      end
    end

    assign o_dout[p*DATA_W +: DATA_W] = rdata;
    assign o_rd_pend[p] = !ra_zero && pend_q[ra] && !(rel_hit && !claim_hit);
  end

endmodule

// File: tb/tb_grf_nrd_sb.sv
// Directed bench for grf_nrd_sb: one instance with plain R0 and one with
// hardwired-zero R0, both three read ports, driven from the same inputs.
module tb_grf_nrd_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            clk_en;
  logic            cs_b;
  logic [AW-1:0]   waddr;
  logic [DW/8-1:0] wen;
  logic [DW-1:0]   din;
  logic            release_i;
  logic            claim;
  logic [AW-1:0]   claim_addr;
  logic [NR*AW-1:0] raddr;

  logic [NR*DW-1:0] dout_a, dout_z;
  logic [NR-1:0]    pend_a, pend_z;
  logic [AW:0]      cnt_a, cnt_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grf_nrd_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_R0(0)) dut (
    .i_clk(clk), .i_rst_b(rst_b), .i_clk_en(clk_en), .i_cs_b(cs_b),
    .i_waddr(waddr), .i_wen(wen), .i_din(din), .i_release(release_i),
    .i_claim(claim), .i_claim_addr(claim_addr), .i_raddr(raddr),
    .o_dout(dout_a), .o_rd_pend(pend_a), .o_pend_cnt(cnt_a)
  );

  grf_nrd_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_R0(1)) dut_z (
    .i_clk(clk), .i_rst_b(rst_b), .i_clk_en(clk_en), .i_cs_b(cs_b),
    .i_waddr(waddr), .i_wen(wen), .i_din(din), .i_release(release_i),
    .i_claim(claim), .i_claim_addr(claim_addr), .i_raddr(raddr),
    .o_dout(dout_z), .o_rd_pend(pend_z), .o_pend_cnt(cnt_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cs_b = 1'b1; wen = '0; din = '0; waddr = '0;
    release_i = 1'b0; claim = 1'b0; claim_addr = '0;
  endtask

  // Advance one clock; inputs change and outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    cs_b = 1'b0; waddr = a; wen = be; din = d;
  endtask

  initial begin
    rst_b = 1'b0; clk_en = 1'b1; raddr = '0;
    idle();
    #12;
    raddr = {4'd0, 4'd0, 4'd3};
    #1;
    chk("reset_dout", dout_a[31:0], 32'h0);
    chk("reset_cnt", 32'(cnt_a), 32'd0);
    rst_b = 1'b1;
    step();

    // Write R3 and claim R8, then an asynchronous reset mid-cycle.
    wr(4'd3, 4'hF, 32'hDEADBEEF);
    claim = 1'b1; claim_addr = 4'd8;
    #1;
    chk("wr_bypass_r3", dout_a[31:0], 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("wr_stored_r3", dout_a[31:0], 32'hDEADBEEF);
    chk("claim_cnt_pre_rst", 32'(cnt_a), 32'd1);
    #1;
    rst_b = 1'b0;
    #1;
    chk("rst_async_dout", dout_a[31:0], 32'h0);
    chk("rst_async_cnt", 32'(cnt_a), 32'd0);
    #1;
    rst_b = 1'b1;
    step();

    // Byte-merge write.
    wr(4'd5, 4'hF, 32'h11223344);
    step();
    wr(4'd5, 4'b0101, 32'hAABBCCDD);
    raddr = {4'd0, 4'd0, 4'd5};
    #1;
    chk("merge_bypass", dout_a[31:0], 32'h11BB33DD);
    step();
    idle();
    #1;
    chk("merge_stored", dout_a[31:0], 32'h11BB33DD);

    // Three ports on R7 while R2 is being written.
    wr(4'd7, 4'hF, 32'h5A5A5A5A);
    step();
    wr(4'd2, 4'hF, 32'hCAFEF00D);
    raddr = {4'd7, 4'd7, 4'd7};
    #1;
    chk("mp_port0", dout_a[31:0], 32'h5A5A5A5A);
    chk("mp_port1", dout_a[63:32], 32'h5A5A5A5A);
    chk("mp_port2", dout_a[95:64], 32'h5A5A5A5A);
    raddr = {4'd2, 4'd7, 4'd7};
    #1;
    chk("mp_port2_bypass", dout_a[95:64], 32'hCAFEF00D);
    chk("mp_port0_keep", dout_a[31:0], 32'h5A5A5A5A);
    step();
    idle();

    // Scoreboard claim and release of R4.
    claim = 1'b1; claim_addr = 4'd4;
    raddr = {4'd0, 4'd0, 4'd4};
    #1;
    chk("claim_not_bypassed", 32'(pend_a[0]), 32'd0);
    step();
    idle();
    #1;
    chk("claim_pend", 32'(pend_a[0]), 32'd1);
    chk("claim_cnt", 32'(cnt_a), 32'd1);
    wr(4'd4, 4'hF, 32'h00000001);
    release_i = 1'b1;
    #1;
    chk("release_bypass_pend", 32'(pend_a[0]), 32'd0);
    chk("release_cnt_before", 32'(cnt_a), 32'd1);
    step();
    idle();
    #1;
    chk("release_cnt_after", 32'(cnt_a), 32'd0);
    chk("release_pend_after", 32'(pend_a[0]), 32'd0);

    // Same-address claim/release collision on R6.
    claim = 1'b1; claim_addr = 4'd6;
    step();
    idle();
    raddr = {4'd0, 4'd0, 4'd6};
    #1;
    chk("coll_cnt_pre", 32'(cnt_a), 32'd1);
    cs_b = 1'b0; waddr = 4'd6; release_i = 1'b1;
    claim = 1'b1; claim_addr = 4'd6;
    #1;
    chk("coll_pend_same_cycle", 32'(pend_a[0]), 32'd1);
    step();
    idle();
    #1;
    chk("coll_pend_after", 32'(pend_a[0]), 32'd1);
    chk("coll_cnt_after", 32'(cnt_a), 32'd1);

    // Claim R1 while releasing pending R2.
    claim = 1'b1; claim_addr = 4'd2;
    step();
    idle();
    #1;
    chk("claim_r2_cnt", 32'(cnt_a), 32'd2);
    cs_b = 1'b0; waddr = 4'd2; release_i = 1'b1;
    claim = 1'b1; claim_addr = 4'd1;
    step();
    idle();
    raddr = {4'd0, 4'd2, 4'd1};
    #1;
    chk("xclaim_cnt", 32'(cnt_a), 32'd2);
    chk("xclaim_pend_r1", 32'(pend_a[0]), 32'd1);
    chk("xclaim_pend_r2", 32'(pend_a[1]), 32'd0);

    // Release of a register that is not pending.
    cs_b = 1'b0; waddr = 4'd9; release_i = 1'b1;
    step();
    idle();
    #1;
    chk("rel_nonpend_cnt", 32'(cnt_a), 32'd2);

    // Write and claim R0 on both variants.
    wr(4'd0, 4'hF, 32'hFFFFFFFF);
    claim = 1'b1; claim_addr = 4'd0;
    raddr = {4'd0, 4'd0, 4'd0};
    #1;
    chk("z_r0_bypass", dout_z[31:0], 32'h0);
    chk("a_r0_bypass", dout_a[31:0], 32'hFFFFFFFF);
    step();
    idle();
    #1;
    chk("z_r0_dout", dout_z[31:0], 32'h0);
    chk("z_r0_pend", 32'(pend_z[0]), 32'd0);
    chk("z_r0_cnt", 32'(cnt_z), 32'd2);
    chk("a_r0_dout", dout_a[31:0], 32'hFFFFFFFF);
    chk("a_r0_pend", 32'(pend_a[0]), 32'd1);
    chk("a_r0_cnt", 32'(cnt_a), 32'd3);

    // Clock enable low: bypass visible, no state change.
    clk_en = 1'b0;
    wr(4'd9, 4'hF, 32'h12345678);
    claim = 1'b1; claim_addr = 4'd10;
    raddr = {4'd0, 4'd0, 4'd9};
    #1;
    chk("cen0_bypass", dout_z[31:0], 32'h12345678);
    step();
    idle();
    clk_en = 1'b1;
    #1;
    chk("cen0_r9_kept", dout_z[31:0], 32'h0);
    chk("cen0_cnt_kept", 32'(cnt_z), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
